// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU datapath, the data-side access unit and
// RAM port B. The slave view belongs to the access unit; the master view
// is the surrounding CPU and RAM.
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_done;
  logic             cpu_busy;
  logic             mem_we_b;
  logic [WIDTH-1:0] mem_addr_b;
  logic [WIDTH-1:0] mem_data_b;
  logic [WIDTH-1:0] mem_q_b;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_busy,
    input  mem_we_b, mem_addr_b, mem_data_b,
    output mem_q_b
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_busy,
    output mem_we_b, mem_addr_b, mem_data_b,
    input  mem_q_b
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-side access unit: sequences one load or store at a time against
// RAM port B (one-cycle registered read) and maps IO_ADDR onto a
// debounced button code instead of RAM.
module mem_access_unit #(
  parameter int               WIDTH           = 16,
  parameter logic [WIDTH-1:0] IO_ADDR         = 16'hFFFF,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  input  logic              btn_start_n,
  input  logic              btn_left_n,
  input  logic              btn_right_n
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int         NBTN     = 3;
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           state_next;

  logic             we_l;
  logic             io_hit;
  logic [WIDTH-1:0] addr_l;
  logic [WIDTH-1:0] wdata_l;
  logic [WIDTH-1:0] rdata;

  // Button index 0 = start, 1 = left, 2 = right; all active-low.
  logic [NBTN-1:0]  raw_n;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  deb;
  logic [15:0]      cnt [NBTN];
  logic [WIDTH-1:0] btn_code;

  assign raw_n = {btn_right_n, btn_left_n, btn_start_n};

  assign bus.mem_addr_b = addr_l;
  assign bus.mem_data_b = wdata_l;
  assign bus.cpu_rdata  = rdata;

  // State register; the sequence is fixed once a request is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control outputs. The RAM write enable is also gated by
  // reset so a store caught in ISSUE at a reset edge never lands in RAM.
  always_comb begin
    state_next   = state;
    bus.cpu_done = 1'b0;
    bus.cpu_busy = 1'b1;
    bus.mem_we_b = 1'b0;
    case (state)
      IDLE: begin
        bus.cpu_busy = 1'b0;
        if (bus.cpu_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next   = WAIT;
        bus.mem_we_b = we_l && !io_hit && reset;
      end
      WAIT: begin
        state_next = DONE;
      end
      DONE: begin
        state_next   = IDLE;
        bus.cpu_done = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the request on acceptance and capture the load result in WAIT,
  // when the RAM's registered read data is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_l    <= 1'b0;
      io_hit  <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && bus.cpu_req) begin
        we_l    <= bus.cpu_we;
        io_hit  <= (bus.cpu_addr == IO_ADDR);
        addr_l  <= bus.cpu_addr;
        wdata_l <= bus.cpu_wdata;
      end
      if (state == WAIT && !we_l) begin
        rdata <= io_hit ? btn_code : bus.mem_q_b;
      end
    end
  end

  // Two-flop synchronise each raw button, then accept a change only after
  // it has held for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      for (int i = 0; i < NBTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Prioritised button code: start > left > right, zero when none pressed.
  always_comb begin
    btn_code = '0;
    if (!deb[0]) begin
      btn_code[1:0] = 2'd1;
    end else if (!deb[1]) begin
      btn_code[1:0] = 2'd2;
    end else if (!deb[2]) begin
      btn_code[1:0] = 2'd3;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a behavioural RAM port B, a
// scoreboard queue of expected load results, and button stimulus against
// a short debounce window.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  logic btn_start_n;
  logic btn_left_n;
  logic btn_right_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb[$];
  logic [15:0] held;

  logic [15:0] ram [0:65535];
  int          write_count = 0;

  mem_access_unit_if #(.WIDTH(16)) bus ();

  mem_access_unit #(
    .WIDTH          (16),
    .IO_ADDR        (16'hFFFF),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .btn_start_n(btn_start_n),
    .btn_left_n (btn_left_n),
    .btn_right_n(btn_right_n)
  );

  always #5 clk = ~clk;

  // RAM port B model: write on enable, registered read one cycle later.
  always @(posedge clk) begin
    if (bus.mem_we_b) begin
      ram[bus.mem_addr_b] <= bus.mem_data_b;
      write_count <= write_count + 1;
    end
    bus.mem_q_b <= ram[bus.mem_addr_b];
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete transaction: drive, check ISSUE outputs, wait for the
  // completion pulse with a bounded budget, then score the result.
  task automatic apply_stimulus(input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata,
                                input logic [15:0] load_value);
    int          wc0;
    int          lat;
    logic        found;
    logic        exp_we;
    logic [15:0] exp;
    exp_we = we && (addr != 16'hFFFF);
    exp    = we ? held : load_value;
    sb.push_back(exp);
    if (!we) held = load_value;
    @(negedge clk);
    wc0           = write_count;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check_output("issue_busy", bus.cpu_busy, 1);
    check_output("issue_we", bus.mem_we_b, exp_we);
    check_output("issue_addr", bus.mem_addr_b, addr);
    if (we) check_output("issue_data", bus.mem_data_b, wdata);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.cpu_done) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check_output("latency", lat, 3);
    exp = sb.pop_front();
    if (found) check_output("rdata", bus.cpu_rdata, exp);
    check_output("write_pulses", write_count - wc0, exp_we ? 1 : 0);
    @(negedge clk);
    check_output("done_pulse_end", bus.cpu_done, 0);
    check_output("idle_busy", bus.cpu_busy, 0);
  endtask

  // Directed sequence covering reset, RAM, IO, debounce, throughput and
  // reset abort.
  initial begin
    int          ndone;
    int          wc;
    logic [15:0] ffff_before;

    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    btn_start_n   = 1'b1;
    btn_left_n    = 1'b1;
    btn_right_n   = 1'b1;
    held          = 16'h0000;

    wait_cycles(3);
    check_output("rst_rdata", bus.cpu_rdata, 0);
    check_output("rst_done", bus.cpu_done, 0);
    check_output("rst_busy", bus.cpu_busy, 0);
    check_output("rst_we", bus.mem_we_b, 0);
    check_output("rst_addr", bus.mem_addr_b, 0);
    check_output("rst_data", bus.mem_data_b, 0);
    reset = 1'b1;
    wait_cycles(2);

    $display("[TB] memory round trip");
    apply_stimulus(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    check_output("ram_0010", ram[16'h0010], 16'hBEEF);
    apply_stimulus(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    apply_stimulus(1'b1, 16'h0033, 16'h5A5A, 16'h0000);
    apply_stimulus(1'b0, 16'h0033, 16'h0000, 16'h5A5A);

    $display("[TB] io read with left button");
    btn_left_n = 1'b0;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0002);
    btn_left_n = 1'b1;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000);

    $display("[TB] bounce rejection");
    @(negedge clk);
    btn_start_n = 1'b0;
    wait_cycles(2);
    btn_start_n = 1'b1;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    btn_start_n = 1'b0;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0001);

    $display("[TB] priority");
    btn_right_n = 1'b0;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0001);
    btn_start_n = 1'b1;
    wait_cycles(10);
    apply_stimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0003);
    btn_right_n = 1'b1;
    wait_cycles(10);

    $display("[TB] request held high");
    @(negedge clk);
    repeat (4) sb.push_back(16'hBEEF);
    held          = 16'hBEEF;
    ndone         = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0010;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        check_output("held_done_pos", i, 3 + 4 * ndone);
        check_output("held_rdata", bus.cpu_rdata, sb.pop_front());
        ndone++;
      end
    end
    bus.cpu_req = 1'b0;
    check_output("held_done_count", ndone, 4);
    check_output("held_sb_empty", sb.size(), 0);
    @(negedge clk);
    check_output("held_no_extra", bus.cpu_busy, 0);

    $display("[TB] io store");
    ffff_before = ram[16'hFFFF];
    apply_stimulus(1'b1, 16'hFFFF, 16'h1234, 16'h0000);
    check_output("ram_ffff", ram[16'hFFFF], ffff_before);

    $display("[TB] reset mid transaction");
    apply_stimulus(1'b1, 16'h0020, 16'hCAFE, 16'h0000);
    @(negedge clk);
    wc            = write_count;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0020;
    bus.cpu_wdata = 16'h1111;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check_output("abort_issue_we", bus.mem_we_b, 1);
    reset = 1'b0;
    #1;
    check_output("abort_we_gated", bus.mem_we_b, 0);
    @(negedge clk);
    check_output("abort_busy", bus.cpu_busy, 0);
    check_output("abort_done", bus.cpu_done, 0);
    check_output("abort_rdata", bus.cpu_rdata, 0);
    check_output("abort_addr", bus.mem_addr_b, 0);
    check_output("abort_data", bus.mem_data_b, 0);
    reset = 1'b1;
    held  = 16'h0000;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.cpu_done) ndone++;
    end
    check_output("abort_no_done", ndone, 0);
    check_output("abort_no_write", write_count - wc, 0);
    check_output("abort_ram_0020", ram[16'h0020], 16'hCAFE);
    apply_stimulus(1'b0, 16'h0020, 16'h0000, 16'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
